// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: two-state fetch/exec sequencer with PC update, 8-deep return stack.
// Define INSTR_FETCH_INTERRUPT_EN to build in interrupt entry/return; otherwise reti acts as ret.
module instr_fetch_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        inst_cyc_o,
  output logic        inst_stb_o,
  output logic [11:0] inst_adr_o,
  input  logic        inst_ack_i,
  input  logic        next_c,
  input  logic        branch_c,
  input  logic        jmp_c,
  input  logic        jsb_c,
  input  logic        ret_c,
  input  logic        reti_c,
  input  logic [1:0]  func_e,
  input  logic        ccZ_e,
  input  logic        ccC_e,
  input  logic [7:0]  disp_e,
  input  logic [11:0] addr_e,
  input  logic        int_req_i,
  output logic        int_ack_o,
  output logic        intz_o,
  output logic        intc_o,
  output logic        stack_err_o
);

  typedef enum logic {FETCH, EXEC} state_t;

  state_t      state, state_nxt;
  logic [11:0] pc, pc_inc, pc_cmd;
  logic [11:0] stack_mem [8];
  logic [2:0]  sp, sp_dec;
  logic [3:0]  depth;
  logic        any_cmd, br_taken, update, do_push, do_pop, take_int;

`ifdef INSTR_FETCH_INTERRUPT_EN
  logic [11:0] int_pc;
  logic        int_en, is_reti;
`endif

  assign pc_inc     = pc + 12'd1;
  assign sp_dec     = sp - 3'd1;
  assign inst_adr_o = pc;
  assign any_cmd    = next_c | branch_c | jmp_c | jsb_c | ret_c | reti_c;

  always_comb begin
    case (func_e)
      2'b00:   br_taken = ccZ_e;
      2'b01:   br_taken = ~ccZ_e;
      2'b10:   br_taken = ccC_e;
      default: br_taken = ~ccC_e;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= FETCH;
    else       state <= state_nxt;
  end

  // Command priority: reti > ret > jsb > jmp > branch > next.
  always_comb begin
    state_nxt  = state;
    inst_cyc_o = 1'b0;
    inst_stb_o = 1'b0;
    update     = 1'b0;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    pc_cmd     = pc_inc;
`ifdef INSTR_FETCH_INTERRUPT_EN
    is_reti    = 1'b0;
`endif
    if (state == FETCH) begin
      inst_cyc_o = ~rst_i;
      inst_stb_o = ~rst_i;
      if (inst_ack_i) state_nxt = EXEC;
    end else if (any_cmd) begin
      state_nxt = FETCH;
      update    = 1'b1;
      if (reti_c) begin
`ifdef INSTR_FETCH_INTERRUPT_EN
        is_reti = 1'b1;
        pc_cmd  = int_pc;
`else
        do_pop  = 1'b1;
        pc_cmd  = stack_mem[sp_dec];
`endif
      end else if (ret_c) begin
        do_pop = 1'b1;
        pc_cmd = stack_mem[sp_dec];
      end else if (jsb_c) begin
        do_push = 1'b1;
        pc_cmd  = addr_e;
      end else if (jmp_c) begin
        pc_cmd = addr_e;
      end else if (branch_c) begin
        pc_cmd = br_taken ? pc_inc + {{4{disp_e[7]}}, disp_e} : pc_inc;
      end
    end
  end

  // Depth tracks occupancy so a full push and an empty pop can be flagged; sp wraps either way.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc          <= 12'h000;
      sp          <= 3'd0;
      depth       <= 4'd0;
      stack_err_o <= 1'b0;
    end else if (update) begin
      pc <= take_int ? 12'h001 : pc_cmd;
      if (do_push) begin
        sp <= sp + 3'd1;
        if (depth == 4'd8) stack_err_o <= 1'b1;
        else               depth <= depth + 4'd1;
      end
      if (do_pop) begin
        sp <= sp_dec;
        if (depth == 4'd0) stack_err_o <= 1'b1;
        else               depth <= depth - 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (update && do_push) stack_mem[sp] <= pc_inc;
  end

`ifdef INSTR_FETCH_INTERRUPT_EN
  assign take_int = update & int_req_i & int_en & ~is_reti;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      int_en    <= 1'b1;
      int_pc    <= 12'h000;
      intz_o    <= 1'b0;
      intc_o    <= 1'b0;
      int_ack_o <= 1'b0;
    end else begin
      int_ack_o <= take_int;
      if (take_int) begin
        int_pc <= pc_cmd;
        intz_o <= ccZ_e;
        intc_o <= ccC_e;
        int_en <= 1'b0;
      end else if (update && is_reti) begin
        int_en <= 1'b1;
      end
    end
  end
`else
  logic unused_int_req;
  assign unused_int_req = int_req_i;
  assign take_int       = 1'b0;
  assign int_ack_o      = 1'b0;
  assign intz_o         = 1'b0;
  assign intc_o         = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: expected fetch addresses are queued as commands are issued.
// Interrupt steps are compiled in when INSTR_FETCH_INTERRUPT_EN is defined.
module tb_instr_fetch_unit;

  localparam logic [5:0] C_NEXT = 6'b000001;
  localparam logic [5:0] C_BR   = 6'b000010;
  localparam logic [5:0] C_JMP  = 6'b000100;
  localparam logic [5:0] C_JSB  = 6'b001000;
  localparam logic [5:0] C_RET  = 6'b010000;
  localparam logic [5:0] C_RETI = 6'b100000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        inst_cyc_o, inst_stb_o;
  logic [11:0] inst_adr_o;
  logic        inst_ack_i = 1'b0;
  logic        next_c = 1'b0, branch_c = 1'b0, jmp_c = 1'b0;
  logic        jsb_c = 1'b0, ret_c = 1'b0, reti_c = 1'b0;
  logic [1:0]  func_e = 2'b00;
  logic        ccZ_e = 1'b0, ccC_e = 1'b0;
  logic [7:0]  disp_e = 8'h00;
  logic [11:0] addr_e = 12'h000;
  logic        int_req_i = 1'b0;
  logic        int_ack_o, intz_o, intc_o, stack_err_o;

  int          tests = 0;
  int          fails = 0;
  logic [11:0] expq[$];

  instr_fetch_unit dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .inst_cyc_o(inst_cyc_o), .inst_stb_o(inst_stb_o), .inst_adr_o(inst_adr_o),
    .inst_ack_i(inst_ack_i),
    .next_c(next_c), .branch_c(branch_c), .jmp_c(jmp_c),
    .jsb_c(jsb_c), .ret_c(ret_c), .reti_c(reti_c),
    .func_e(func_e), .ccZ_e(ccZ_e), .ccC_e(ccC_e),
    .disp_e(disp_e), .addr_e(addr_e), .int_req_i(int_req_i),
    .int_ack_o(int_ack_o), .intz_o(intz_o), .intc_o(intc_o),
    .stack_err_o(stack_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a fetch, compare its address with the scoreboard, ack it.
  task automatic awaitFetch(input string tag);
    int n = 0;
    logic [11:0] exp;
    #1;
    while (!inst_stb_o && n < 20) begin
      @(negedge clk_i); #1;
      n++;
    end
    if (!inst_stb_o) begin
      tests++;
      fails++;
      $error("[TB] FAIL %s_timeout: observed no strobe, expected strobe", tag);
    end else if (expq.size() == 0) begin
      tests++;
      fails++;
      $error("[TB] FAIL %s_sb_empty: observed fetch %h, expected none", tag, inst_adr_o);
    end else begin
      exp = expq.pop_front();
      checkOutput(tag, inst_adr_o, exp);
      inst_ack_i = 1'b1;
      @(negedge clk_i); #1;
      inst_ack_i = 1'b0;
      checkOutput({tag, "_stb_low"}, {11'b0, inst_stb_o}, 12'h000);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] cmd, input logic [1:0] func, input logic [7:0] disp,
                               input logic [11:0] addr, input logic z, input logic c,
                               input logic irq, input logic [11:0] exp);
    {reti_c, ret_c, jsb_c, jmp_c, branch_c, next_c} = cmd;
    func_e    = func;
    disp_e    = disp;
    addr_e    = addr;
    ccZ_e     = z;
    ccC_e     = c;
    int_req_i = irq;
    expq.push_back(exp);
    @(negedge clk_i); #1;
    {reti_c, ret_c, jsb_c, jmp_c, branch_c, next_c} = 6'b0;
    int_req_i = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    #1;
    checkOutput("rst_stb", {11'b0, inst_stb_o}, 12'h000);
    checkOutput("rst_adr", inst_adr_o, 12'h000);
    checkOutput("rst_err", {11'b0, stack_err_o}, 12'h000);
    checkOutput("rst_ack", {11'b0, int_ack_o}, 12'h000);
    checkOutput("rst_zc", {10'b0, intz_o, intc_o}, 12'h000);
    rst_i = 1'b0;
    #1;
    checkOutput("first_stb", {11'b0, inst_stb_o}, 12'h001);
    expq.push_back(12'h000);
    awaitFetch("f000");

    applyStimulus(C_NEXT, 2'b00, 8'h00, 12'h000, 0, 0, 0, 12'h001); awaitFetch("f001");
    applyStimulus(C_NEXT, 2'b00, 8'h00, 12'h000, 0, 0, 0, 12'h002); awaitFetch("f002");

    applyStimulus(C_JMP, 2'b00, 8'h00, 12'h010, 0, 0, 0, 12'h010); awaitFetch("jmp010");
    applyStimulus(C_BR,  2'b00, 8'hFE, 12'h000, 1, 0, 0, 12'h00F); awaitFetch("bz_taken");
    applyStimulus(C_JMP, 2'b00, 8'h00, 12'h010, 0, 0, 0, 12'h010); awaitFetch("jmp010b");
    applyStimulus(C_BR,  2'b00, 8'hFE, 12'h000, 0, 0, 0, 12'h011); awaitFetch("bz_not");
    applyStimulus(C_BR,  2'b01, 8'h05, 12'h000, 0, 0, 0, 12'h017); awaitFetch("bnz_taken");
    applyStimulus(C_BR,  2'b10, 8'h80, 12'h000, 0, 1, 0, 12'hF98); awaitFetch("bc_neg_wrap");
    applyStimulus(C_BR,  2'b11, 8'h02, 12'h000, 0, 1, 0, 12'hF99); awaitFetch("bnc_not");
    applyStimulus(C_BR,  2'b11, 8'h02, 12'h000, 0, 0, 0, 12'hF9C); awaitFetch("bnc_taken");
    applyStimulus(C_BR,  2'b10, 8'h02, 12'h000, 0, 0, 0, 12'hF9D); awaitFetch("bc_not");

    applyStimulus(C_JMP,  2'b00, 8'h00, 12'hFFF, 0, 0, 0, 12'hFFF); awaitFetch("jmpFFF");
    applyStimulus(C_NEXT, 2'b00, 8'h00, 12'h000, 0, 0, 0, 12'h000); awaitFetch("pc_wrap");

    repeat (3) @(negedge clk_i);
    #1;
    checkOutput("exec_hold_stb", {11'b0, inst_stb_o}, 12'h000);
    checkOutput("exec_hold_adr", inst_adr_o, 12'h000);
    applyStimulus(C_NEXT, 2'b00, 8'h00, 12'h000, 0, 0, 0, 12'h001); awaitFetch("after_hold");

    applyStimulus(C_JMP | C_NEXT, 2'b00, 8'h00, 12'h123, 0, 0, 0, 12'h123); awaitFetch("jmp_over_next");
    applyStimulus(C_JSB | C_JMP | C_BR, 2'b00, 8'h00, 12'h200, 1, 0, 0, 12'h200); awaitFetch("jsb_over_jmp");
    applyStimulus(C_RET | C_JSB, 2'b00, 8'h00, 12'h400, 0, 0, 0, 12'h124); awaitFetch("ret_over_jsb");

    applyStimulus(C_JMP, 2'b00, 8'h00, 12'h050, 0, 0, 0, 12'h050); awaitFetch("jmp050");
    applyStimulus(C_JSB, 2'b00, 8'h00, 12'h200, 0, 0, 0, 12'h200); awaitFetch("jsb200");
    applyStimulus(C_RET, 2'b00, 8'h00, 12'h000, 0, 0, 0, 12'h051); awaitFetch("ret051");

    for (int i = 0; i < 9; i++) begin
      applyStimulus(C_JSB, 2'b00, 8'h00, 12'h300 + 12'(16 * i), 0, 0, 0, 12'h300 + 12'(16 * i));
      awaitFetch("nest_jsb");
      if (i == 7) checkOutput("err_at_8", {11'b0, stack_err_o}, 12'h000);
    end
    checkOutput("err_at_9", {11'b0, stack_err_o}, 12'h001);
    applyStimulus(C_RET, 2'b00, 8'h00, 12'h000, 0, 0, 0, 12'h371); awaitFetch("ret_newest");
    applyStimulus(C_RET, 2'b00, 8'h00, 12'h000, 0, 0, 0, 12'h361); awaitFetch("ret_second");
`ifndef INSTR_FETCH_INTERRUPT_EN
    applyStimulus(C_RETI, 2'b00, 8'h00, 12'h000, 0, 0, 1, 12'h351); awaitFetch("reti_as_ret");
    checkOutput("noirq_ack", {11'b0, int_ack_o}, 12'h000);
`endif

    applyStimulus(C_NEXT, 2'b00, 8'h00, 12'h000, 0, 0, 0, 12'h000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i); #1;
      checkOutput("stall_stb", {11'b0, inst_stb_o}, 12'h001);
    end
    rst_i = 1'b1;
    @(negedge clk_i); #1;
    checkOutput("abort_stb", {11'b0, inst_stb_o}, 12'h000);
    checkOutput("abort_adr", inst_adr_o, 12'h000);
    checkOutput("abort_err", {11'b0, stack_err_o}, 12'h000);
    rst_i = 1'b0;
    expq.delete();
    expq.push_back(12'h000);
    awaitFetch("refetch000");

`ifdef INSTR_FETCH_INTERRUPT_EN
    applyStimulus(C_JMP, 2'b00, 8'h00, 12'h020, 0, 0, 0, 12'h020); awaitFetch("jmp020");
    applyStimulus(C_NEXT, 2'b00, 8'h00, 12'h000, 1, 0, 1, 12'h001);
    checkOutput("irq_ack", {11'b0, int_ack_o}, 12'h001);
    checkOutput("irq_zc", {10'b0, intz_o, intc_o}, 12'h002);
    awaitFetch("irq_vec");
    checkOutput("irq_ack_once", {11'b0, int_ack_o}, 12'h000);
    applyStimulus(C_NEXT, 2'b00, 8'h00, 12'h000, 0, 0, 1, 12'h002);
    checkOutput("irq_masked", {11'b0, int_ack_o}, 12'h000);
    awaitFetch("isr_next");
    applyStimulus(C_RETI, 2'b00, 8'h00, 12'h000, 0, 1, 1, 12'h021);
    checkOutput("reti_no_irq", {11'b0, int_ack_o}, 12'h000);
    awaitFetch("reti021");
    applyStimulus(C_NEXT, 2'b00, 8'h00, 12'h000, 0, 1, 1, 12'h001);
    checkOutput("irq2_ack", {11'b0, int_ack_o}, 12'h001);
    checkOutput("irq2_zc", {10'b0, intz_o, intc_o}, 12'h001);
    awaitFetch("irq2_vec");
    applyStimulus(C_RETI, 2'b00, 8'h00, 12'h000, 0, 0, 0, 12'h022); awaitFetch("reti022");
`else
    applyStimulus(C_NEXT, 2'b00, 8'h00, 12'h000, 1, 1, 1, 12'h001);
    checkOutput("irq_ignored_ack", {11'b0, int_ack_o}, 12'h000);
    checkOutput("irq_ignored_zc", {10'b0, intz_o, intc_o}, 12'h000);
    awaitFetch("irq_ignored_pc");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk_i  in  1  system clock; all state updates on its rising edge.
REQ-003 rst_i  in  1  synchronous reset, active high.
REQ-004 inst_cyc_o, inst_stb_o  out  1  instruction-bus cycle and strobe.
REQ-005 inst_adr_o  out  12  instruction address; equals pc.
REQ-006 inst_ack_i  in  1  instruction-bus acknowledge.
REQ-007 next_c, branch_c, jmp_c, jsb_c, ret_c, reti_c  in  1 each  PC-update commands from the control unit.
REQ-008 func_e  in  2  branch condition: 00 bz, 01 bnz, 10 bc, 11 bnc.
REQ-009 ccZ_e, ccC_e  in  1  condition flags from the processing unit.
REQ-010 disp_e  in  8  signed branch displacement.
REQ-011 addr_e  in  12  jump or subroutine target.
REQ-012 int_req_i  in  1  level interrupt request.
REQ-013 int_ack_o  out  1  one-cycle interrupt-taken pulse.
REQ-014 intz_o, intc_o  out  1  saved Z and C flags, restored on reti.
REQ-015 stack_err_o  out  1  sticky return-stack overflow or underflow.

Function
REQ-016 The FSM SHALL have two states. FETCH drives inst_cyc_o=inst_stb_o=1 and moves to EXEC on inst_ack_i=1. EXEC drives inst_cyc_o=inst_stb_o=0 and ignores inst_ack_i.
REQ-017 In EXEC, the first cycle with any command asserted SHALL update pc and return to FETCH; EXEC with no command holds pc and state.
REQ-018 Simultaneous commands SHALL resolve by priority reti > ret > jsb > jmp > branch > next.
REQ-019 The PC update per command SHALL be:
  - next: pc+1.
  - branch taken: pc+1+sign_extend(disp_e).
  - branch not taken: pc+1.
  - jmp and jsb: addr_e.
  - ret: the popped address.
  - reti: int_pc.
REQ-020 All PC arithmetic SHALL be modulo 2^12 (wrap-around, 12'hFFF+1=12'h000).
REQ-021 The return stack SHALL hold 8 entries of 12 bits with a 3-bit pointer. jsb pushes pc+1; ret pops.
REQ-022 A push with 8 entries held SHALL overwrite the oldest entry (the pointer wraps) and set stack_err_o. A pop when empty SHALL wrap the pointer and set stack_err_o.
REQ-023 Interrupts SHALL be taken only at an EXEC-to-FETCH transition, when int_req_i=1, int_en=1, and the command is not reti. On that transition:
  - the computed next pc is saved to int_pc;
  - ccZ_e and ccC_e are saved to intz_o and intc_o;
  - pc becomes 12'h001;
  - int_en is cleared;
  - int_ack_o=1 for exactly that one cycle.
REQ-024 reti SHALL set int_en=1. An interrupt requested during that same reti transition is taken at the next instruction boundary.
REQ-025 Branch condition evaluation SHALL use ccZ_e and ccC_e as sampled in the command cycle.

Reset
REQ-026 On rst_i=1 the block SHALL set:
  - pc=12'h000, state=FETCH, stack pointer=0;
  - int_en=1, int_pc=0;
  - intz_o=intc_o=0, int_ack_o=0, stack_err_o=0.
REQ-027 Reset during FETCH SHALL abandon the bus cycle. The first fetch after reset is to address 12'h000, with inst_stb_o=1 in the first cycle rst_i=0.
REQ-028 Stack entry contents SHALL be unaffected by reset.

Configuration
REQ-029 Macro INSTR_FETCH_INTERRUPT_EN defined: REQ-023 and REQ-024 are implemented.
REQ-030 Macro INSTR_FETCH_INTERRUPT_EN undefined: the following are tied to 0 and int_req_i is ignored:
  - int_ack_o, intz_o, intc_o;
  - int_pc and int_en (no state kept).
  In this build, reti SHALL behave as ret.

Verification
REQ-031 After reset, ack every fetch immediately and issue next each EXEC -> inst_adr_o sequence 000, 001, 002; stb high one cycle per fetch.
REQ-032 At pc=12'h010 with ccZ_e=1, func_e=00, disp_e=8'hFE -> next inst_adr_o=12'h00F. Repeat with ccZ_e=0 -> 12'h011.
REQ-033 Wrap cases:
  - pc=12'hFFF, next -> pc=12'h000.
  - jsb to 12'h200 from pc=12'h050, then ret -> fetch 12'h051.
  - 9 nested jsb -> stack_err_o=1.
REQ-034 With int_req_i=1, ccZ_e=1 and ccC_e=0 during next at pc=12'h020:
  - int_ack_o pulses once, fetch goes to 12'h001, intz_o=1 and intc_o=0;
  - a later reti returns to 12'h021 with int_en=1.
REQ-035 Hold inst_ack_i=0 for 5 cycles then assert rst_i -> stb drops the following cycle and the next fetch is to 12'h000. Simultaneous jmp_c and next_c -> jmp wins.
